demux_nx1_hs: RTL and testbench

DEMUX_NX1_HS -- requirements
Module: demux_nx1_hs

---
 rtl/demux_nx1_hs_if.sv | 44 ++++
 rtl/demux_nx1_hs.sv | 81 ++++++++
 tb/tb_demux_nx1_hs.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_nx1_hs_if.sv
// demux_nx1_hs_if: upstream word port plus per-channel downstream ports
// and drop-error status for the 1-to-N handshake demux.
interface demux_nx1_hs_if #(
  parameter int N_OUT = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_bcast;
  logic [WIDTH-1:0]       in_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic                   sel_err;
  logic [7:0]             err_count;

  modport master (
    output in_valid,
    output in_sel,
    output in_bcast,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel_err,
    input  err_count
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_bcast,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel_err,
    output err_count
  );
endinterface

// File: rtl/demux_nx1_hs.sv
// demux_nx1_hs: 1-to-N demux with a 1-deep buffer per channel,
// unicast/broadcast routing and counted drop of out-of-range selects.
module demux_nx1_hs #(
  parameter int N_OUT = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  demux_nx1_hs_if.slave bus
);
  logic [N_OUT-1:0]            hit;
  logic [N_OUT-1:0]            can_take;
  logic [N_OUT-1:0]            load;
  logic [N_OUT-1:0]            valid_q;
  logic [N_OUT-1:0][WIDTH-1:0] data_q;
  logic                        in_range;
  logic                        xfer;
  logic                        drop;
  logic                        err_q;
  logic [7:0]                  cnt_q;

  // a full buffer being drained this cycle can take a new word
  assign can_take = ~valid_q | bus.out_ready;

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  assign in_range = |hit;

  always_comb begin
    bus.in_ready = 1'b0;
    unique case (1'b1)
      bus.in_bcast:
        bus.in_ready = &can_take;
      !bus.in_bcast && !in_range:
        bus.in_ready = 1'b1;
      default:
        bus.in_ready = |(hit & can_take);
    endcase
  end

  assign xfer = bus.in_valid & bus.in_ready;
  assign drop = xfer & ~bus.in_bcast & ~in_range;

  always_comb begin
    load = '0;
    if (xfer) begin
      load = bus.in_bcast ? {N_OUT{1'b1}} : hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      valid_q <= load | (valid_q & ~bus.out_ready);
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.in_data;
        end
      end
      err_q <= drop;
      if (drop && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel_err   = err_q;
  assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_demux_nx1_hs.sv
// tb_demux_nx1_hs: directed scenarios plus a per-channel scoreboard
// on an 8-channel instance and out-of-range drops on a 6-channel one.
module tb_demux_nx1_hs;
  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  demux_nx1_hs_if #(.N_OUT(8), .WIDTH(8), .SEL_W(3)) b8 ();
  demux_nx1_hs_if #(.N_OUT(6), .WIDTH(8), .SEL_W(3)) b6 ();

  demux_nx1_hs #(.N_OUT(8), .WIDTH(8), .SEL_W(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  demux_nx1_hs #(.N_OUT(6), .WIDTH(8), .SEL_W(3)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } ent_t;

  ent_t sb[$];

  function automatic int find_ch(int k);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].ch == k) return i;
    end
    return -1;
  endfunction

  logic [7:0] occ;
  logic [7:0] ct;
  logic       exp_r;
  logic       exp_v;
  logic [7:0] got_d;
  int         idx;
  ent_t       ent;

  // outputs are compared against the model between edges, then the
  // handshakes that the coming edge will complete are applied to it
  always @(negedge clk) begin
    if (rst_n) begin
      occ = '0;
      for (int k = 0; k < 8; k++) begin
        idx   = find_ch(k);
        exp_v = (idx >= 0);
        occ[k] = exp_v;
        vectors++;
        if (b8.out_valid[k] !== exp_v) begin
          miscompares++;
          $display("FAIL sb_valid ch%0d: got %b want %b",
                   k, b8.out_valid[k], exp_v);
        end
        if (exp_v) begin
          got_d = b8.out_data[k*8 +: 8];
          vectors++;
          if (got_d !== sb[idx].d) begin
            miscompares++;
            $display("FAIL sb_data ch%0d: got %h want %h",
                     k, got_d, sb[idx].d);
          end
        end
      end
      vectors++;
      if ({b8.sel_err, b8.err_count} !== 9'd0) begin
        miscompares++;
        $display("FAIL sb_err8: got err=%b cnt=%0d want 0/0",
                 b8.sel_err, b8.err_count);
      end
      ct = ~occ | b8.out_ready;
      exp_r = b8.in_bcast ? &ct : ct[b8.in_sel];
      vectors++;
      if (b8.in_ready !== exp_r) begin
        miscompares++;
        $display("FAIL sb_ready: got %b want %b", b8.in_ready, exp_r);
      end
      for (int k = 0; k < 8; k++) begin
        if (occ[k] && b8.out_ready[k]) begin
          idx = find_ch(k);
          sb.delete(idx);
        end
      end
      if (b8.in_valid && exp_r) begin
        for (int k = 0; k < 8; k++) begin
          if (b8.in_bcast || b8.in_sel == 3'(k)) begin
            ent.ch = k;
            ent.d  = b8.in_data;
            sb.push_back(ent);
          end
        end
      end
    end
  end

  always @(negedge rst_n) sb.delete();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b8.out_valid !== 8'h00 || b8.out_data !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%h d=%h want 0/0",
               b8.out_valid, b8.out_data);
    end
    vectors++;
    if (b8.sel_err !== 1'b0 || b8.err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_err: got %b/%0d want 0/0",
               b8.sel_err, b8.err_count);
    end
    b8.in_valid = 1'b1;
    b8.in_bcast = 1'b1;
    tick();
    tick();
    vectors++;
    if (b8.out_valid !== 8'h00 || b6.out_valid !== 6'h00) begin
      miscompares++;
      $display("FAIL reset_clocked: got %h/%h want 0/0",
               b8.out_valid, b6.out_valid);
    end
    b8.in_valid = 1'b0;
    b8.in_bcast = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    b8.out_ready = 8'h00;
    b8.in_valid  = 1'b1;
    b8.in_sel    = 3'd5;
    b8.in_data   = 8'hA5;
    #1;
    vectors++;
    if (b8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL uni_ready: got %b want 1", b8.in_ready);
    end
    tick();
    vectors++;
    if (b8.out_valid !== 8'h20) begin
      miscompares++;
      $display("FAIL uni_valid: got %h want 20", b8.out_valid);
    end
    vectors++;
    if (b8.out_data[47:40] !== 8'hA5) begin
      miscompares++;
      $display("FAIL uni_data: got %h want a5", b8.out_data[47:40]);
    end
    b8.in_data = 8'h99;
    #1;
    vectors++;
    if (b8.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL uni_full: got %b want 0", b8.in_ready);
    end
  endtask

  task automatic test_drain_refill();
    b8.out_ready = 8'h20;
    b8.in_data   = 8'h3C;
    #1;
    vectors++;
    if (b8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL refill_ready: got %b want 1", b8.in_ready);
    end
    tick();
    vectors++;
    if (b8.out_valid !== 8'h20 || b8.out_data[47:40] !== 8'h3C) begin
      miscompares++;
      $display("FAIL refill_out: got v=%h d=%h want 20/3c",
               b8.out_valid, b8.out_data[47:40]);
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 8'hFF;
    tick();
    vectors++;
    if (b8.out_valid !== 8'h00 || b8.out_data[47:40] !== 8'h3C) begin
      miscompares++;
      $display("FAIL drain_keep: got v=%h d=%h want 00/3c",
               b8.out_valid, b8.out_data[47:40]);
    end
  endtask

  task automatic test_bcast();
    b8.out_ready = 8'h00;
    b8.in_valid  = 1'b1;
    b8.in_sel    = 3'd2;
    b8.in_data   = 8'h11;
    tick();
    b8.in_bcast = 1'b1;
    b8.in_sel   = 3'd6;
    b8.in_data  = 8'h77;
    #1;
    vectors++;
    if (b8.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bcast_block: got %b want 0", b8.in_ready);
    end
    tick();
    vectors++;
    if (b8.out_valid !== 8'h04) begin
      miscompares++;
      $display("FAIL bcast_partial: got %h want 04", b8.out_valid);
    end
    b8.out_ready = 8'h04;
    #1;
    vectors++;
    if (b8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bcast_ready: got %b want 1", b8.in_ready);
    end
    tick();
    b8.in_valid  = 1'b0;
    b8.in_bcast  = 1'b0;
    b8.out_ready = 8'h00;
    vectors++;
    if (b8.out_valid !== 8'hFF) begin
      miscompares++;
      $display("FAIL bcast_valid: got %h want ff", b8.out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (b8.out_data[k*8 +: 8] !== 8'h77) begin
        miscompares++;
        $display("FAIL bcast_data ch%0d: got %h want 77",
                 k, b8.out_data[k*8 +: 8]);
      end
    end
    b8.out_ready = 8'hFF;
    tick();
  endtask

  task automatic test_reset_mid();
    b8.out_ready = 8'h00;
    b8.in_valid  = 1'b1;
    b8.in_sel    = 3'd1;
    b8.in_data   = 8'hC1;
    tick();
    b8.in_sel  = 3'd3;
    b8.in_data = 8'hC3;
    tick();
    b8.in_sel  = 3'd6;
    b8.in_data = 8'hC6;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    b8.in_valid = 1'b0;
    vectors++;
    if (b8.out_valid !== 8'h00 || b8.out_data !== 64'd0) begin
      miscompares++;
      $display("FAIL midrst_clear: got v=%h d=%h want 0/0",
               b8.out_valid, b8.out_data);
    end
    @(posedge clk);
    #2;
    vectors++;
    if (b8.out_valid !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_hold: got %h want 00", b8.out_valid);
    end
    #1;
    rst_n       = 1'b1;
    b8.in_valid = 1'b1;
    b8.in_sel   = 3'd3;
    b8.in_data  = 8'h5A;
    #1;
    vectors++;
    if (b8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_rst_ready: got %b want 1", b8.in_ready);
    end
    tick();
    b8.in_valid = 1'b0;
    vectors++;
    if (b8.out_valid !== 8'h08 || b8.out_data[31:24] !== 8'h5A) begin
      miscompares++;
      $display("FAIL post_rst_word: got v=%h d=%h want 08/5a",
               b8.out_valid, b8.out_data[31:24]);
    end
    b8.out_ready = 8'hFF;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      b8.in_valid  = ($urandom_range(0, 3) != 0);
      b8.in_bcast  = ($urandom_range(0, 7) == 0);
      b8.in_sel    = 3'($urandom_range(0, 7));
      b8.in_data   = 8'($urandom);
      b8.out_ready = 8'($urandom);
      tick();
    end
    b8.in_valid  = 1'b0;
    b8.in_bcast  = 1'b0;
    b8.out_ready = 8'hFF;
    tick();
    tick();
    vectors++;
    if (sb.size() != 0 || b8.out_valid !== 8'h00) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d left v=%h want 0/00",
               sb.size(), b8.out_valid);
    end
  endtask

  task automatic test_oor();
    int want;
    b6.out_ready = 6'h00;
    b6.in_valid  = 1'b1;
    b6.in_bcast  = 1'b0;
    b6.in_sel    = 3'd7;
    for (int i = 0; i < 300; i++) begin
      b6.in_data = 8'($urandom);
      #1;
      vectors++;
      if (b6.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL oor_ready %0d: got %b want 1", i, b6.in_ready);
      end
      tick();
      want = (i < 255) ? i + 1 : 255;
      vectors++;
      if (b6.sel_err !== 1'b1 || b6.out_valid !== 6'h00) begin
        miscompares++;
        $display("FAIL oor_pulse %0d: got err=%b v=%h want 1/00",
                 i, b6.sel_err, b6.out_valid);
      end
      vectors++;
      if (b6.err_count !== 8'(want)) begin
        miscompares++;
        $display("FAIL oor_count %0d: got %0d want %0d",
                 i, b6.err_count, want);
      end
    end
    b6.in_valid = 1'b0;
    tick();
    vectors++;
    if (b6.sel_err !== 1'b0 || b6.err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL oor_idle: got %b/%0d want 0/255",
               b6.sel_err, b6.err_count);
    end
    b6.in_bcast = 1'b1;
    tick();
    vectors++;
    if (b6.out_valid !== 6'h00 || b6.sel_err !== 1'b0) begin
      miscompares++;
      $display("FAIL novalid_bcast: got v=%h e=%b want 00/0",
               b6.out_valid, b6.sel_err);
    end
    b6.in_bcast = 1'b0;
    b6.in_valid = 1'b1;
    b6.in_sel   = 3'd6;
    tick();
    vectors++;
    if (b6.sel_err !== 1'b1 || b6.err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL oor_sel6: got %b/%0d want 1/255",
               b6.sel_err, b6.err_count);
    end
    b6.in_sel  = 3'd5;
    b6.in_data = 8'h4E;
    tick();
    b6.in_valid = 1'b0;
    vectors++;
    if (b6.out_valid !== 6'h20 || b6.out_data[47:40] !== 8'h4E) begin
      miscompares++;
      $display("FAIL n6_edge: got v=%h d=%h want 20/4e",
               b6.out_valid, b6.out_data[47:40]);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b1;
    b8.in_valid  = 1'b0;
    b8.in_sel    = '0;
    b8.in_bcast  = 1'b0;
    b8.in_data   = '0;
    b8.out_ready = '0;
    b6.in_valid  = 1'b0;
    b6.in_sel    = '0;
    b6.in_bcast  = 1'b0;
    b6.in_data   = '0;
    b6.out_ready = '0;
    #1;
    test_reset();
    test_unicast();
    test_drain_refill();
    test_bcast();
    test_reset_mid();
    test_random();
    test_oor();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
